// File: rtl/abcd_sweep_checker_pkg.sv
// Shared definitions for the ABCD sweep checker.
//   - FSM state encoding (IDLE/WAIT/SAMPLE/DONE)
//   - Truth-table, index and error-counter widths
//   - Helper that returns a truth table with one bit replaced
package abcd_sweep_checker_pkg;

    localparam int TT_W  = 16;
    localparam int IDX_W = 4;
    localparam int ERR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Returns tt with bit idx replaced by val; lets the final pass compare
    // include the bit that is being captured in the same cycle.
    function automatic logic [TT_W-1:0] tt_put_bit(
        input logic [TT_W-1:0]  tt,
        input logic [IDX_W-1:0] idx,
        input logic             val
    );
        logic [TT_W-1:0] res;
        res      = tt;
        res[idx] = val;
        return res;
    endfunction

endpackage

// File: rtl/abcd_sweep_checker.sv
// abcd_sweep_checker
//   Exhaustive sweep driver and response checker for a 4-input, 1-output
//   combinational block F(A,B,C,D). Walks {a,b,c,d} through 0..15, holds each
//   code SETTLE cycles before sampling f in a one-cycle SAMPLE slot, builds the
//   16-bit truth table and compares it with EXPECTED.
// Parameters
//   SETTLE   : cycles the stimulus is held before f is sampled (>= 1)
//   EXPECTED : golden truth table, bit i = F at ABCD = i
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : begin a sweep (accepted only in IDLE or DONE)
//   abort          : synchronous cancel, wins over start
//   f              : response from the function block
//   a,b,c,d        : registered stimulus, {a,b,c,d} = current code
//   busy, done     : sweep in progress / result valid and held
//   pass           : tt == EXPECTED (valid with done)
//   tt             : captured truth table
//   err_cnt        : number of mismatching bits (0..16)
//   first_err_idx  : lowest mismatching code (valid when err_cnt != 0)
module abcd_sweep_checker
    import abcd_sweep_checker_pkg::*;
#(
    parameter int unsigned      SETTLE   = 1,
    parameter logic [TT_W-1:0]  EXPECTED = 16'h4525
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              f,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [TT_W-1:0]   tt,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [IDX_W-1:0]  first_err_idx
);

    // Settle counter only needs to hold SETTLE-1.
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] WAIT_RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = 4'd15;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]   abcd_q, abcd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [TT_W-1:0]    tt_q, tt_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [IDX_W-1:0]   first_err_idx_q, first_err_idx_d;

    logic [TT_W-1:0]    tt_next_s;
    logic               mismatch_s;

    // Next-state and next-output computation for the sweep FSM.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        wait_cnt_d      = wait_cnt_q;
        abcd_d          = abcd_q;
        busy_d          = busy_q;
        done_d          = done_q;
        pass_d          = pass_q;
        tt_d            = tt_q;
        err_cnt_d       = err_cnt_q;
        first_err_idx_d = first_err_idx_q;

        tt_next_s  = tt_put_bit(tt_q, idx_q, f);
        mismatch_s = f ^ EXPECTED[idx_q];

        if (abort) begin
            state_d         = ST_IDLE;
            idx_d           = 4'd0;
            wait_cnt_d      = {CNT_W{1'b0}};
            abcd_d          = 4'd0;
            busy_d          = 1'b0;
            done_d          = 1'b0;
            pass_d          = 1'b0;
            tt_d            = 16'h0000;
            err_cnt_d       = 5'd0;
            first_err_idx_d = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d         = ST_WAIT;
                        idx_d           = 4'd0;
                        wait_cnt_d      = WAIT_RELOAD;
                        abcd_d          = 4'd0;
                        busy_d          = 1'b1;
                        done_d          = 1'b0;
                        pass_d          = 1'b0;
                        tt_d            = 16'h0000;
                        err_cnt_d       = 5'd0;
                        first_err_idx_d = 4'd0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == {CNT_W{1'b0}}) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_SAMPLE: begin
                    tt_d = tt_next_s;
                    if (mismatch_s) begin
                        err_cnt_d = err_cnt_q + 5'd1;
                        // Count still zero means this is the lowest failing code.
                        if (err_cnt_q == 5'd0) begin
                            first_err_idx_d = idx_q;
                        end else begin
                            first_err_idx_d = first_err_idx_q;
                        end
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (tt_next_s == EXPECTED);
                    end else begin
                        state_d    = ST_WAIT;
                        idx_d      = idx_q + 4'd1;
                        abcd_d     = idx_q + 4'd1;
                        wait_cnt_d = WAIT_RELOAD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            idx_q           <= 4'd0;
            wait_cnt_q      <= {CNT_W{1'b0}};
            abcd_q          <= 4'd0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            tt_q            <= 16'h0000;
            err_cnt_q       <= 5'd0;
            first_err_idx_q <= 4'd0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            wait_cnt_q      <= wait_cnt_d;
            abcd_q          <= abcd_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            tt_q            <= tt_d;
            err_cnt_q       <= err_cnt_d;
            first_err_idx_q <= first_err_idx_d;
        end
    end

    assign a             = abcd_q[3];
    assign b             = abcd_q[2];
    assign c             = abcd_q[1];
    assign d             = abcd_q[0];
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign tt            = tt_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_abcd_sweep_checker.sv
// Directed bench for abcd_sweep_checker: one instance with SETTLE=1 driven by a
// selectable F block (correct / tied 0 / tied 1), and one with SETTLE=3 whose F
// is deliberately wrong except in the 4th cycle each code is held.
module tb_abcd_sweep_checker;

    logic clk = 1'b0;
    logic rst_n, start, abort, start2;
    logic [1:0] mode;

    logic f1, a1, b1, c1, d1, busy1, done1, pass1;
    logic [15:0] tt1;
    logic [4:0]  err1;
    logic [3:0]  first1;
    logic [3:0]  code1;

    logic f2, a2, b2, c2, d2, busy2, done2, pass2;
    logic [15:0] tt2;
    logic [4:0]  err2;
    logic [3:0]  first2;
    logic [3:0]  code2;

    int tests = 0;
    int fails = 0;
    int n;

    int          hold2 = 0;
    int          ncodes2 = 0;
    logic [3:0]  last2 = 4'd0;
    logic        busy2_prev = 1'b0;

    always #5 clk = ~clk;

    // Function under test: minterms 0,2,5,8,10,14.
    function automatic logic golden(input logic [3:0] x);
        case (x)
            4'd0, 4'd2, 4'd5, 4'd8, 4'd10, 4'd14: golden = 1'b1;
            default:                              golden = 1'b0;
        endcase
    endfunction

    assign code1 = {a1, b1, c1, d1};
    assign code2 = {a2, b2, c2, d2};

    // F block for instance 1, selected by mode.
    always_comb begin
        case (mode)
            2'd1:    f1 = 1'b0;
            2'd2:    f1 = 1'b1;
            default: f1 = golden(code1);
        endcase
    end

    // Instance 2 only sees a correct F in the 4th held cycle of each code.
    assign f2 = (hold2 == 4) ? golden(code2) : ~golden(code2);

    abcd_sweep_checker #(.SETTLE(1), .EXPECTED(16'h4525)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f(f1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .pass(pass1), .tt(tt1), .err_cnt(err1), .first_err_idx(first1)
    );

    abcd_sweep_checker #(.SETTLE(3), .EXPECTED(16'h4525)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .f(f2),
        .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2),
        .pass(pass2), .tt(tt2), .err_cnt(err2), .first_err_idx(first2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start on instance 1 and count edges until done (bounded).
    task automatic sweep1(output int edges);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        while (!done1 && edges < 300) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic step1(input int k);
        repeat (k) begin
            @(posedge clk); #1;
        end
    endtask

    // Tracks how long instance 2 holds each code and the code order.
    always @(posedge clk) begin
        #1;
        if (busy2 && !busy2_prev) begin
            hold2   = 1;
            last2   = code2;
            ncodes2 = 1;
            check("s3_first_code", {28'd0, code2}, 32'd0);
        end else if (busy2) begin
            if (code2 != last2) begin
                check("s3_hold", 32'(hold2), 32'd4);
                check("s3_seq", {28'd0, code2}, 32'(last2) + 32'd1);
                last2 = code2;
                hold2 = 1;
                ncodes2++;
            end else begin
                hold2++;
            end
        end else if (busy2_prev) begin
            check("s3_last_hold", 32'(hold2), 32'd4);
            check("s3_last_code", {28'd0, last2}, 32'd15);
            check("s3_ncodes", 32'(ncodes2), 32'd16);
        end
        busy2_prev = busy2;
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        start2 = 1'b0;
        mode   = 2'd0;
        step1(2);

        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_done", {31'd0, done1}, 32'd0);
        check("rst_pass", {31'd0, pass1}, 32'd0);
        check("rst_tt", {16'd0, tt1}, 32'd0);
        check("rst_err", {27'd0, err1}, 32'd0);
        check("rst_code", {28'd0, code1}, 32'd0);
        rst_n = 1'b1;
        step1(1);

        // Correct F block.
        sweep1(n);
        check("t1_done_edge", 32'(n), 32'd32);
        check("t1_tt", {16'd0, tt1}, 32'h4525);
        check("t1_pass", {31'd0, pass1}, 32'd1);
        check("t1_err", {27'd0, err1}, 32'd0);
        check("t1_busy", {31'd0, busy1}, 32'd0);

        // F tied low / high.
        mode = 2'd1;
        sweep1(n);
        check("t2z_tt", {16'd0, tt1}, 32'h0000);
        check("t2z_pass", {31'd0, pass1}, 32'd0);
        check("t2z_err", {27'd0, err1}, 32'd6);
        check("t2z_first", {28'd0, first1}, 32'd0);
        mode = 2'd2;
        sweep1(n);
        check("t2o_tt", {16'd0, tt1}, 32'hFFFF);
        check("t2o_pass", {31'd0, pass1}, 32'd0);
        check("t2o_err", {27'd0, err1}, 32'd10);
        check("t2o_first", {28'd0, first1}, 32'd1);
        mode = 2'd0;

        // Start after done begins a fresh sweep; a re-pulse mid-sweep is ignored.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_done_drop", {31'd0, done1}, 32'd0);
        check("t4_busy", {31'd0, busy1}, 32'd1);
        n = 0;
        while (!done1 && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (n == 10) begin
                check("t4_code5", {28'd0, code1}, 32'd5);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("t4_done_edge", 32'(n), 32'd32);
        check("t4_tt", {16'd0, tt1}, 32'h4525);
        check("t4_pass", {31'd0, pass1}, 32'd1);

        // Abort together with start at code 7.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        step1(14);
        check("t5_code7", {28'd0, code1}, 32'd7);
        check("t5_partial_tt", {16'd0, tt1}, 32'h0025);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check("t5_busy", {31'd0, busy1}, 32'd0);
        check("t5_code", {28'd0, code1}, 32'd0);
        check("t5_tt", {16'd0, tt1}, 32'd0);
        check("t5_done", {31'd0, done1}, 32'd0);
        step1(3);
        check("t5_stay_idle", {31'd0, busy1}, 32'd0);

        // Abort from DONE clears the held result.
        sweep1(n);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t5d_done", {31'd0, done1}, 32'd0);
        check("t5d_pass", {31'd0, pass1}, 32'd0);
        check("t5d_tt", {16'd0, tt1}, 32'd0);

        // Asynchronous reset mid-sweep at code 9, then a clean sweep.
        mode = 2'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        step1(18);
        check("t6_code9", {28'd0, code1}, 32'd9);
        check("t6_err_pre", {27'd0, err1}, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", {31'd0, busy1}, 32'd0);
        check("t6_rst_code", {28'd0, code1}, 32'd0);
        check("t6_rst_err", {27'd0, err1}, 32'd0);
        check("t6_rst_tt", {16'd0, tt1}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mode  = 2'd0;
        sweep1(n);
        check("t6_done_edge", 32'(n), 32'd32);
        check("t6_tt", {16'd0, tt1}, 32'h4525);
        check("t6_pass", {31'd0, pass1}, 32'd1);

        // SETTLE=3 instance: 4 cycles per code, f only trusted in the 4th.
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("t3_done_edge", 32'(n), 32'd64);
        check("t3_tt", {16'd0, tt2}, 32'h4525);
        check("t3_pass", {31'd0, pass2}, 32'd1);
        check("t3_err", {27'd0, err2}, 32'd0);
        check("t3_first", {28'd0, first2}, 32'd0);
        step1(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
